// File: rtl/series_engine.sv
// series_engine: self-sequencing unsigned fixed-point power-series evaluator.
//   result = sum_k (+/-) term_k, term_0 = start_odd ? x : ONE,
//   term_{k+1} = ((term_k * x^2) >> FRAC) * c[k] >> CW. Stops early when a
//   term falls below the latched threshold, or after N_TERMS terms.
// Ports:
//   clk, rst (async, active-low)
//   start/x/thresh/sign_alt/start_odd : run request and its arguments
//   coef_we/coef_addr/coef_wdata      : coefficient table write (IDLE/DONE only)
//   busy, done, result, terms_used, sat : run status and result
module series_engine #(
  parameter int W       = 10,
  parameter int FRAC    = 8,
  parameter int CW      = 8,
  parameter int TW      = 8,
  parameter int N_TERMS = 8,
  parameter int AW      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x,
  input  logic [TW-1:0] thresh,
  input  logic          sign_alt,
  input  logic          start_odd,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_wdata,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [AW:0]   terms_used,
  output logic          sat
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SQR   = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_MUL_X = 3'd3;
  localparam logic [2:0] S_MUL_C = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [W-1:0] ONE = W'(1) << FRAC;

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  x_q, x_d, x2_q, x2_d, term_q, term_d, result_q, result_d;
  logic [TW-1:0] thresh_q, thresh_d;
  logic          sign_alt_q, sign_alt_d, start_odd_q, start_odd_d, sat_q, sat_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW:0]   terms_used_q, terms_used_d;
  logic [CW-1:0] coef_q [N_TERMS];
  logic [CW-1:0] coef_d [N_TERMS];

  // Single shared multiplier: x*x in SQR, term*x2 in MUL_X, term*c[k] in MUL_C.
  logic [W-1:0]   mul_a, mul_b, mul_res;
  logic [2*W-1:0] prod, prod_sh;
  logic           mul_sat;
  logic [W:0]     acc_sum;
  logic [W-1:0]   acc_res;
  logic           acc_sub, acc_sat;

  always_comb begin
    mul_a = (state_q == S_SQR) ? x_q : term_q;
    mul_b = x2_q;
    if (state_q == S_SQR)   mul_b = x_q;
    if (state_q == S_MUL_C) mul_b = W'(coef_q[k_q]);
    prod    = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    prod_sh = (state_q == S_MUL_C) ? (prod >> CW) : (prod >> FRAC);
    mul_sat = |prod_sh[2*W-1:W];
    mul_res = mul_sat ? '1 : prod_sh[W-1:0];

    // Odd-indexed terms subtract in alternating mode; both directions clamp.
    acc_sub = sign_alt_q & k_q[0];
    acc_sum = {1'b0, result_q} + {1'b0, term_q};
    if (acc_sub) begin
      acc_sat = term_q > result_q;
      acc_res = acc_sat ? '0 : result_q - term_q;
    end else begin
      acc_sat = acc_sum[W];
      acc_res = acc_sat ? '1 : acc_sum[W-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    x2_d         = x2_q;
    term_d       = term_q;
    result_d     = result_q;
    thresh_d     = thresh_q;
    sign_alt_d   = sign_alt_q;
    start_odd_d  = start_odd_q;
    sat_d        = sat_q;
    k_d          = k_q;
    terms_used_d = terms_used_q;
    coef_d       = coef_q;

    if (coef_we && (state_q == S_IDLE || state_q == S_DONE) &&
        ({1'b0, coef_addr} < (AW+1)'(N_TERMS)))
      coef_d[coef_addr] = coef_wdata;

    case (state_q)
      S_IDLE: if (start) begin
        x_d          = x;
        thresh_d     = thresh;
        sign_alt_d   = sign_alt;
        start_odd_d  = start_odd;
        result_d     = '0;
        terms_used_d = '0;
        sat_d        = 1'b0;
        state_d      = S_SQR;
      end
      S_SQR: begin
        x2_d    = mul_res;
        sat_d   = sat_q | mul_sat;
        term_d  = start_odd_q ? x_q : ONE;
        k_d     = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (term_q < W'(thresh_q)) begin
          state_d = S_DONE;
        end else begin
          result_d     = acc_res;
          sat_d        = sat_q | acc_sat;
          terms_used_d = {1'b0, k_q} + (AW+1)'(1);
          state_d      = (k_q == AW'(N_TERMS-1)) ? S_DONE : S_MUL_X;
        end
      end
      S_MUL_X: begin
        term_d  = mul_res;
        sat_d   = sat_q | mul_sat;
        state_d = S_MUL_C;
      end
      S_MUL_C: begin
        term_d  = mul_res;
        sat_d   = sat_q | mul_sat;
        k_d     = k_q + AW'(1);
        state_d = S_CHECK;
      end
      default: state_d = S_IDLE;  // S_DONE and illegal codes
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      x2_q         <= '0;
      term_q       <= '0;
      result_q     <= '0;
      thresh_q     <= '0;
      sign_alt_q   <= 1'b0;
      start_odd_q  <= 1'b0;
      sat_q        <= 1'b0;
      k_q          <= '0;
      terms_used_q <= '0;
      for (int i = 0; i < N_TERMS; i++) coef_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      x2_q         <= x2_d;
      term_q       <= term_d;
      result_q     <= result_d;
      thresh_q     <= thresh_d;
      sign_alt_q   <= sign_alt_d;
      start_odd_q  <= start_odd_d;
      sat_q        <= sat_d;
      k_q          <= k_d;
      terms_used_q <= terms_used_d;
      coef_q       <= coef_d;
    end
  end

  assign busy       = (state_q == S_SQR) || (state_q == S_CHECK) ||
                      (state_q == S_MUL_X) || (state_q == S_MUL_C);
  assign done       = (state_q == S_DONE);
  assign result     = result_q;
  assign terms_used = terms_used_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_series_engine.sv
// Directed bench for series_engine with N_TERMS=4. Edges are numbered with the
// edge that samples start as edge 1; "done after edge n" means done is seen
// high 1 time unit after edge n.
module tb_series_engine;
  logic       clk, rst, start, sign_alt, start_odd, coef_we;
  logic [9:0] x;
  logic [7:0] thresh, coef_wdata;
  logic [1:0] coef_addr;
  logic       busy, done, sat;
  logic [9:0] result;
  logic [2:0] terms_used;
  int n_checks = 0;
  int n_err = 0;

  series_engine #(.W(10), .FRAC(8), .CW(8), .TW(8), .N_TERMS(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .thresh(thresh),
    .sign_alt(sign_alt), .start_odd(start_odd), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy), .done(done),
    .result(result), .terms_used(terms_used), .sat(sat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_coefs(input logic [7:0] c0, c1, c2, c3);
    logic [7:0] cv [4];
    cv = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      coef_we = 1'b1; coef_addr = 2'(i); coef_wdata = cv[i];
      tick();
    end
    coef_we = 1'b0;
  endtask

  // Start a run and watch 50 edges; reports first done edge (0 = none) and pulse count.
  task automatic run(input logic [9:0] xv, input logic [7:0] tv, input logic sa, so,
                     output int done_edge, output int n_done, output logic busy1);
    x = xv; thresh = tv; sign_alt = sa; start_odd = so; start = 1'b1;
    tick();
    start = 1'b0; busy1 = busy; done_edge = 0; n_done = 0;
    for (int e = 2; e <= 50; e++) begin
      tick();
      if (done) begin
        n_done++;
        if (done_edge == 0) done_edge = e;
      end
    end
  endtask

  task automatic test_reset();
    int de, nd; logic b1;
    rst = 1'b0; start = 1'b1; x = 10'd256; coef_we = 1'b1; coef_addr = 2'd1; coef_wdata = 8'hAA;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0d exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0d exp 0", done); end
    n_checks++; if (result !== 10'd0) begin n_err++; $display("FAIL reset_result got %0d exp 0", result); end
    n_checks++; if (terms_used !== 3'd0) begin n_err++; $display("FAIL reset_terms got %0d exp 0", terms_used); end
    n_checks++; if (sat !== 1'b0) begin n_err++; $display("FAIL reset_sat got %0d exp 0", sat); end
    start = 1'b0; coef_we = 1'b0; rst = 1'b1;
    tick();
    // All-zero table: 256 then zeros, no early stop with thresh=0.
    run(10'd256, 8'd0, 1'b0, 1'b0, de, nd, b1);
    n_checks++; if (result !== 10'd256) begin n_err++; $display("FAIL zero_table_result got %0d exp 256", result); end
    n_checks++; if (terms_used !== 3'd4) begin n_err++; $display("FAIL zero_table_terms got %0d exp 4", terms_used); end
  endtask

  task automatic test_sat();
    int de, nd; logic b1;
    load_coefs(8'd255, 8'd255, 8'd255, 8'd255);
    // terms 256, 573, 1019 (product clamped), 1019 -> sum clamps at 1023
    run(10'd384, 8'd0, 1'b0, 1'b0, de, nd, b1);
    n_checks++; if (result !== 10'd1023) begin n_err++; $display("FAIL sat_result got %0d exp 1023", result); end
    n_checks++; if (sat !== 1'b1) begin n_err++; $display("FAIL sat_flag got %0d exp 1", sat); end
    n_checks++; if (terms_used !== 3'd4) begin n_err++; $display("FAIL sat_terms got %0d exp 4", terms_used); end
    // alternating: 256 - 573 -> clamp 0, +1019, -1019 -> 0
    run(10'd384, 8'd0, 1'b1, 1'b0, de, nd, b1);
    n_checks++; if (result !== 10'd0) begin n_err++; $display("FAIL sat_sub_result got %0d exp 0", result); end
    n_checks++; if (sat !== 1'b1) begin n_err++; $display("FAIL sat_sub_flag got %0d exp 1", sat); end
  endtask

  task automatic test_basic();
    int de, nd; logic b1;
    load_coefs(8'd128, 8'd128, 8'd128, 8'd128);
    run(10'd256, 8'd0, 1'b0, 1'b0, de, nd, b1);
    n_checks++; if (b1 !== 1'b1) begin n_err++; $display("FAIL basic_busy_e1 got %0d exp 1", b1); end
    n_checks++; if (result !== 10'd480) begin n_err++; $display("FAIL basic_result got %0d exp 480", result); end
    n_checks++; if (terms_used !== 3'd4) begin n_err++; $display("FAIL basic_terms got %0d exp 4", terms_used); end
    n_checks++; if (sat !== 1'b0) begin n_err++; $display("FAIL basic_sat got %0d exp 0", sat); end
    n_checks++; if (de !== 12) begin n_err++; $display("FAIL basic_done_edge got %0d exp 12", de); end
    n_checks++; if (nd !== 1) begin n_err++; $display("FAIL basic_done_pulses got %0d exp 1", nd); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy got %0d exp 0", busy); end
  endtask

  task automatic test_sign_alt();
    int de, nd; logic b1;
    run(10'd256, 8'd0, 1'b1, 1'b0, de, nd, b1);
    n_checks++; if (result !== 10'd160) begin n_err++; $display("FAIL alt_result got %0d exp 160", result); end
    n_checks++; if (terms_used !== 3'd4) begin n_err++; $display("FAIL alt_terms got %0d exp 4", terms_used); end
  endtask

  task automatic test_early_stop();
    int de, nd; logic b1;
    run(10'd128, 8'd20, 1'b0, 1'b1, de, nd, b1);
    n_checks++; if (result !== 10'd128) begin n_err++; $display("FAIL early_result got %0d exp 128", result); end
    n_checks++; if (terms_used !== 3'd1) begin n_err++; $display("FAIL early_terms got %0d exp 1", terms_used); end
    n_checks++; if (de !== 6) begin n_err++; $display("FAIL early_done_edge got %0d exp 6", de); end
    n_checks++; if (nd !== 1) begin n_err++; $display("FAIL early_done_pulses got %0d exp 1", nd); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = 0; d2 = 0;
    x = 10'd256; thresh = 8'd0; sign_alt = 1'b0; start_odd = 1'b0; start = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (done) begin if (d1 == 0) d1 = e; else if (d2 == 0) d2 = e; end
      if (e == 13) begin
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_e13 got %0d exp 0", busy); end
        n_checks++; if (result !== 10'd480) begin n_err++; $display("FAIL b2b_result_e13 got %0d exp 480", result); end
      end
      if (e == 14) begin
        n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_e14 got %0d exp 1", busy); end
        n_checks++; if (result !== 10'd0) begin n_err++; $display("FAIL b2b_result_e14 got %0d exp 0", result); end
        start = 1'b0;
      end
    end
    n_checks++; if (d1 !== 12) begin n_err++; $display("FAIL b2b_done1 got %0d exp 12", d1); end
    n_checks++; if (d2 !== 25) begin n_err++; $display("FAIL b2b_done2 got %0d exp 25", d2); end
    n_checks++; if (result !== 10'd480) begin n_err++; $display("FAIL b2b_result got %0d exp 480", result); end
  endtask

  task automatic test_busy_ignore();
    int de, nd;
    de = 0; nd = 0;
    x = 10'd256; thresh = 8'd0; sign_alt = 1'b0; start_odd = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();  // now in MUL_X
    // c[1]=0 would make the result 384 if the write landed
    start = 1'b1; coef_we = 1'b1; coef_addr = 2'd1; coef_wdata = 8'd0;
    tick();
    start = 1'b0; coef_we = 1'b0;
    for (int e = 5; e <= 40; e++) begin
      tick();
      if (done) begin nd++; if (de == 0) de = e; end
    end
    n_checks++; if (result !== 10'd480) begin n_err++; $display("FAIL ignore_result got %0d exp 480", result); end
    n_checks++; if (de !== 12) begin n_err++; $display("FAIL ignore_done_edge got %0d exp 12", de); end
    n_checks++; if (nd !== 1) begin n_err++; $display("FAIL ignore_done_pulses got %0d exp 1", nd); end
  endtask

  task automatic test_reset_midrun();
    int nd;
    nd = 0;
    x = 10'd256; thresh = 8'd0; sign_alt = 1'b0; start_odd = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    for (int e = 2; e <= 5; e++) tick();  // CHECK with k=1, one term accumulated
    n_checks++; if (result !== 10'd256) begin n_err++; $display("FAIL midrun_pre_result got %0d exp 256", result); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrun_busy got %0d exp 0", busy); end
    n_checks++; if (result !== 10'd0) begin n_err++; $display("FAIL midrun_result got %0d exp 0", result); end
    n_checks++; if (terms_used !== 3'd0) begin n_err++; $display("FAIL midrun_terms got %0d exp 0", terms_used); end
    n_checks++; if (done !== 1'b0) begin n_err++; $display("FAIL midrun_done got %0d exp 0", done); end
    tick();
    rst = 1'b1;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (done) nd++;
    end
    n_checks++; if (nd !== 0) begin n_err++; $display("FAIL midrun_no_done got %0d exp 0", nd); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; x = '0; thresh = '0; sign_alt = 1'b0; start_odd = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    test_reset();
    test_sat();
    test_basic();
    test_sign_alt();
    test_early_stop();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
